prefix_unscan: RTL and testbench

Bit-serial inverse of the PrefixTree scan. Accepts one p_WIDTH-bit prefix word over a valid/ready handshake and processes it LSB-first, one bit per clock. Returns the original word (adjacent-difference of the prefix) over a second valid/ready handshake. Sits on the DE1 demo path downstream of PrefixTree and checks round trips: switches → scan → unscan → LEDs.

---
 rtl/prefix_unscan.sv | 135 +++++++++++++
 tb/tb_prefix_unscan.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/prefix_unscan.sv
`default_nettype none
// ============================================================================
// Module   : prefix_unscan
// Brief    : Bit-serial inverse of a prefix scan (XOR or OR). Takes one
//            prefix word LSB-first, one bit per clock, and returns the
//            adjacent-difference word. For OR, also flags any input that
//            is not monotonic.
// Revision : 1.0 - initial release
// ============================================================================
module prefix_unscan #(
  parameter int p_WIDTH = 10,
  parameter int p_OP    = 0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [p_WIDTH-1:0] i_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [p_WIDTH-1:0] o_data,
  output logic               o_err,
  output logic               o_busy
);

  localparam int                 CNT_W    = $clog2(p_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(p_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [p_WIDTH-1:0] shreg;
  logic [p_WIDTH-1:0] result;
  logic [CNT_W-1:0]   cnt;
  logic               prev;
  logic               err;
  logic               cur_bit;
  logic               res_bit;
  logic               err_nxt;
  logic               last_bit;

  assign cur_bit  = shreg[0];
  assign last_bit = (cnt == LAST_CNT);

  // Operator-specific recovery of one result bit and the monotonic check
  generate
    if (p_OP == 1) begin : g_or_inverse
      assign res_bit = cur_bit & ~prev;
      assign err_nxt = err | (prev & ~cur_bit);
    end else begin : g_xor_inverse
      assign res_bit = cur_bit ^ prev;
      assign err_nxt = 1'b0;
    end
  endgenerate

  // State register; reset discards any word in flight immediately
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake decode; outputs depend on state (and reset) only
  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    o_valid   = 1'b0;
    o_busy    = 1'b0;
    case (state)
      IDLE: begin
        o_ready = ~i_rst;
        if (i_valid) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        o_busy = 1'b1;
        if (last_bit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        o_busy  = 1'b1;
        o_valid = 1'b1;
        if (i_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: capture on accept, serially recover bits, publish on last bit
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      shreg  <= '0;
      result <= '0;
      cnt    <= '0;
      prev   <= 1'b0;
      err    <= 1'b0;
      o_data <= '0;
      o_err  <= 1'b0;
    end else if (state == IDLE) begin
      if (i_valid) begin
        shreg <= i_data;
        cnt   <= '0;
        prev  <= 1'b0;
        err   <= 1'b0;
      end
    end else if (state == SHIFT) begin
      // Result bits enter at the MSB so bit 0 lands at index 0 after p_WIDTH shifts
      result <= {res_bit, result[p_WIDTH-1:1]};
      err    <= err_nxt;
      prev   <= cur_bit;
      shreg  <= shreg >> 1;
      cnt    <= cnt + CNT_ONE;
      if (last_bit) begin
        o_data <= {res_bit, result[p_WIDTH-1:1]};
        o_err  <= err_nxt;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prefix_unscan.sv
`default_nettype none
// ============================================================================
// Module   : tb_prefix_unscan
// Brief    : Directed self-checking bench for prefix_unscan, one instance per
//            operator (index 0 = XOR inverse, index 1 = OR inverse).
// Revision : 1.0 - initial release
// ============================================================================
module tb_prefix_unscan;

  logic       clk;
  logic       rst;
  logic       vld   [2];
  logic [9:0] din   [2];
  logic       rdy   [2];
  logic       ordy  [2];
  logic       ovld  [2];
  logic [9:0] dout  [2];
  logic       oerr  [2];
  logic       obusy [2];

  int n_checks = 0;
  int n_errors = 0;

  prefix_unscan #(.p_WIDTH(10), .p_OP(0)) u_xor (
    .i_clk(clk), .i_rst(rst), .i_valid(vld[0]), .o_ready(ordy[0]),
    .i_data(din[0]), .o_valid(ovld[0]), .i_ready(rdy[0]),
    .o_data(dout[0]), .o_err(oerr[0]), .o_busy(obusy[0])
  );

  prefix_unscan #(.p_WIDTH(10), .p_OP(1)) u_or (
    .i_clk(clk), .i_rst(rst), .i_valid(vld[1]), .o_ready(ordy[1]),
    .i_data(din[1]), .o_valid(ovld[1]), .i_ready(rdy[1]),
    .o_data(dout[1]), .o_err(oerr[1]), .o_busy(obusy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present a word in the current (IDLE) cycle and wait for o_valid; lat is
  // the number of clock edges from the accept edge to the first o_valid cycle.
  task automatic accept_and_wait(input int k, input logic [9:0] word, input string tag, output int lat);
    check({tag, "_rdy_before"}, 32'(ordy[k]), 32'd1);
    vld[k] = 1'b1;
    din[k] = word;
    @(posedge clk); #1;
    vld[k] = 1'b0;
    check({tag, "_busy"}, 32'(obusy[k]), 32'd1);
    lat = 1;
    while (!ovld[k] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_word(input int k, input logic [9:0] word, input logic [9:0] exp_d,
                          input logic exp_e, input string tag);
    int lat;
    accept_and_wait(k, word, tag, lat);
    check({tag, "_lat"}, 32'(lat), 32'd11);
    check({tag, "_data"}, 32'(dout[k]), 32'(exp_d));
    check({tag, "_err"}, 32'(oerr[k]), 32'(exp_e));
    rdy[k] = 1'b1;
    @(posedge clk); #1;
    rdy[k] = 1'b0;
    check({tag, "_vld_after"}, 32'(ovld[k]), 32'd0);
    check({tag, "_rdy_after"}, 32'(ordy[k]), 32'd1);
    check({tag, "_busy_after"}, 32'(obusy[k]), 32'd0);
  endtask

  initial begin : stim
    int lat;
    int seen;
    logic [9:0] sw [3];
    logic [9:0] se [3];

    for (int k = 0; k < 2; k++) begin
      vld[k] = 1'b0; din[k] = '0; rdy[k] = 1'b0;
    end
    rst = 1'b1;
    #12;
    // Reset values while reset is held
    for (int k = 0; k < 2; k++) begin
      check("rst_ready", 32'(ordy[k]), 32'd0);
      check("rst_valid", 32'(ovld[k]), 32'd0);
      check("rst_data", 32'(dout[k]), 32'd0);
      check("rst_err", 32'(oerr[k]), 32'd0);
      check("rst_busy", 32'(obusy[k]), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_rel_ready0", 32'(ordy[0]), 32'd1);
    check("rst_rel_ready1", 32'(ordy[1]), 32'd1);

    // XOR inverse
    run_word(0, 10'h3FF, 10'h001, 1'b0, "xor_3ff");
    run_word(0, 10'h155, 10'h3FF, 1'b0, "xor_155");
    run_word(0, 10'h000, 10'h000, 1'b0, "xor_000");

    // OR (thermometer) inverse
    run_word(1, 10'h3F8, 10'h008, 1'b0, "or_3f8");
    run_word(1, 10'h000, 10'h000, 1'b0, "or_000");
    run_word(1, 10'h205, 10'h205, 1'b1, "or_205");

    // Backpressure: result held 5 cycles while a competing word is offered
    accept_and_wait(1, 10'h205, "bp", lat);
    check("bp_lat", 32'(lat), 32'd11);
    for (int i = 0; i < 5; i++) begin
      vld[1] = 1'b1;
      din[1] = 10'h0F0;
      check("bp_valid", 32'(ovld[1]), 32'd1);
      check("bp_data", 32'(dout[1]), 32'h205);
      check("bp_err", 32'(oerr[1]), 32'd1);
      check("bp_ready", 32'(ordy[1]), 32'd0);
      @(posedge clk); #1;
    end
    vld[1] = 1'b0;
    check("bp_valid_last", 32'(ovld[1]), 32'd1);
    rdy[1] = 1'b1;
    @(posedge clk); #1;
    rdy[1] = 1'b0;
    check("bp_xfer_valid", 32'(ovld[1]), 32'd0);
    check("bp_xfer_ready", 32'(ordy[1]), 32'd1);
    check("bp_no_capture", 32'(obusy[1]), 32'd0);
    check("bp_data_kept", 32'(dout[1]), 32'h205);
    check("bp_err_kept", 32'(oerr[1]), 32'd1);

    // Reset in the middle of SHIFT
    check("mid_rdy_before", 32'(ordy[0]), 32'd1);
    vld[0] = 1'b1;
    din[0] = 10'h3FF;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    check("mid_busy_pre", 32'(obusy[0]), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(ordy[0]), 32'd0);
    check("mid_rst_valid", 32'(ovld[0]), 32'd0);
    check("mid_rst_data", 32'(dout[0]), 32'd0);
    check("mid_rst_err", 32'(oerr[0]), 32'd0);
    check("mid_rst_busy", 32'(obusy[0]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (ovld[0] || obusy[0]) seen++;
    end
    check("mid_no_valid", 32'(seen), 32'd0);
    run_word(0, 10'h155, 10'h3FF, 1'b0, "mid_after");

    // Streaming with both handshakes held high
    sw[0] = 10'h3FF; se[0] = 10'h001;
    sw[1] = 10'h155; se[1] = 10'h3FF;
    sw[2] = 10'h000; se[2] = 10'h000;
    seen = 0;
    @(posedge clk); #1;
    vld[0] = 1'b1;
    rdy[0] = 1'b1;
    din[0] = sw[0];
    for (int cyc = 0; cyc < 36; cyc++) begin
      check("str_ready", 32'(ordy[0]), 32'((cyc % 12) == 0));
      check("str_valid", 32'(ovld[0]), 32'((cyc == 11) || (cyc == 23) || (cyc == 35)));
      if (ovld[0] && seen < 3) begin
        check("str_data", 32'(dout[0]), 32'(se[seen]));
        seen++;
      end
      @(posedge clk); #1;
      if (cyc == 0) din[0] = sw[1];
      if (cyc == 12) din[0] = sw[2];
      if (cyc == 24) din[0] = 10'h2AA;
      if (cyc == 34) vld[0] = 1'b0;
    end
    rdy[0] = 1'b0;
    check("str_count", 32'(seen), 32'd3);
    check("str_end_idle", 32'(obusy[0]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
